// File: rtl/pio_regs_pkg.sv
// Register offsets shared by the LED PIO slave and anything that talks to it.
package pio_regs;

  typedef enum logic [2:0] {
    PIO_DATA    = 3'd0,
    PIO_BLINKEN = 3'd1,
    PIO_PERIOD  = 3'd2,
    PIO_RSVD    = 3'd3,
    PIO_OUTSET  = 3'd4,
    PIO_OUTCLR  = 3'd5,
    PIO_TOGGLE  = 3'd6,
    PIO_STATUS  = 3'd7
  } pio_addr_e;

endpackage

// File: rtl/pio_led_blink_out_tick.sv
// Blink prescaler: counts period..0, reloads and flips phase; load restarts it.
module blink_tick_gen #(
  parameter int unsigned CNT_WIDTH    = 24,
  parameter int unsigned RESET_PERIOD = 12500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 load,
  output logic                 phase
);

  localparam logic [CNT_WIDTH-1:0] RESET_CNT = RESET_PERIOD[CNT_WIDTH-1:0];

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 phase_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= RESET_CNT;
      phase_q <= 1'b1;
    end else if (load) begin
      // A restart beats a coincident reload/toggle; period already carries the new value.
      cnt_q   <= period;
      phase_q <= 1'b1;
    end else if (period == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == '0) begin
      cnt_q   <= period;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/pio_led_blink_out.sv
// Avalon-MM LED output PIO with set/clear/toggle writes and per-bit blinking.
module pio_led_blink_out
  import pio_regs::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           CNT_WIDTH    = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned           RESET_PERIOD = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [CNT_WIDTH-1:0] RESET_CNT = RESET_PERIOD[CNT_WIDTH-1:0];

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [CNT_WIDTH-1:0]  wd_cnt;
  logic                  unused_wd;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] blink_en_q, blink_en_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic                  period_load;
  logic                  phase;

  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_cnt    = writedata[CNT_WIDTH-1:0];
  assign unused_wd = ^writedata;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    data_d      = data_q;
    blink_en_d  = blink_en_q;
    period_d    = period_q;
    period_load = 1'b0;
    if (wr) begin
      case (pio_addr_e'(address))
        PIO_DATA:    data_d     = wd_data;
        PIO_BLINKEN: blink_en_d = wd_data;
        PIO_PERIOD: begin
          period_d    = wd_cnt;
          period_load = 1'b1;
        end
        PIO_OUTSET:  data_d     = data_q | wd_data;
        PIO_OUTCLR:  data_d     = data_q & ~wd_data;
        PIO_TOGGLE:  data_d     = data_q ^ wd_data;
        default:     ;
      endcase
    end
  end

  // NOTE: the async reset is the highest-priority branch, so bus writes during reset are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= RESET_CNT;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
    end
  end

  blink_tick_gen #(
    .CNT_WIDTH    (CNT_WIDTH),
    .RESET_PERIOD (RESET_PERIOD)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .period (period_d),
    .load   (period_load),
    .phase  (phase)
  );

  // Purely a mask of flop outputs, so it moves on the same edge as the registers.
  assign out_port = data_q & ~(blink_en_q & {DATA_WIDTH{~phase}});

  always_comb begin
    readdata = '0;
    case (pio_addr_e'(address))
      PIO_DATA:    readdata[DATA_WIDTH-1:0] = data_q;
      PIO_BLINKEN: readdata[DATA_WIDTH-1:0] = blink_en_q;
      PIO_PERIOD:  readdata[CNT_WIDTH-1:0]  = period_q;
      PIO_STATUS:  readdata[0]              = phase;
      default:     ;
    endcase
  end

endmodule
